// File: rtl/pid_1.sv
// Discrete PID speed controller: one update per clock, saturating integrator,
// floor-shifted output clamped into an 8-bit registered PWM duty command.
module pid_1 #(
  parameter int unsigned KP        = 4,
  parameter int unsigned KI        = 1,
  parameter int unsigned KD        = 2,
  parameter int unsigned FRAC_BITS = 3,
  parameter int unsigned INT_LIM   = 4095
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] speed,
  input  logic [7:0] feed,
  output logic [7:0] pwmout
);

  // Integrator wide enough for any 32-bit INT_LIM plus one error step;
  // the sum width covers a 32-bit gain times the largest integrator value.
  localparam int IW = 34;
  localparam int SW = 72;

  localparam logic signed [IW-1:0] LIM_S  = IW'(INT_LIM);
  localparam logic signed [SW-1:0] KP_S   = SW'(KP);
  localparam logic signed [SW-1:0] KI_S   = SW'(KI);
  localparam logic signed [SW-1:0] KD_S   = SW'(KD);
  localparam logic signed [SW-1:0] ZERO_S = SW'(0);
  localparam logic signed [SW-1:0] MAX_S  = SW'(255);

  logic signed [9:0]    e_s;
  logic signed [9:0]    d_s;
  logic signed [9:0]    e_prev_r;
  logic signed [IW-1:0] integ_r;
  logic signed [IW-1:0] isum_s;
  logic signed [IW-1:0] integ_next_s;
  logic signed [SW-1:0] u_s;
  logic signed [SW-1:0] us_s;
  logic [7:0]           pwm_next_s;

  function automatic logic [7:0] clamp_pwm(input logic signed [SW-1:0] v);
    logic [7:0] r;
    if (v < ZERO_S) begin
      r = 8'd0;
    end else if (v > MAX_S) begin
      r = 8'd255;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

  // Error, derivative, clamped integrator and shifted PID sum for this update
  always_comb begin
    e_s  = $signed({2'b00, speed}) - $signed({2'b00, feed});
    d_s  = e_s - e_prev_r;
    isum_s = integ_r + IW'(e_s);
    if (isum_s > LIM_S) begin
      integ_next_s = LIM_S;
    end else if (isum_s < -LIM_S) begin
      integ_next_s = -LIM_S;
    end else begin
      integ_next_s = isum_s;
    end
    u_s = KP_S * SW'(e_s) + KI_S * SW'(integ_next_s) + KD_S * SW'(d_s);
    us_s = u_s >>> FRAC_BITS;
    pwm_next_s = clamp_pwm(us_s);
  end

  // Controller state and registered duty command
  always_ff @(posedge clk) begin
    if (reset) begin
      pwmout   <= 8'd0;
      integ_r  <= '0;
      e_prev_r <= 10'sd0;
    end else begin
      pwmout   <= pwm_next_s;
      integ_r  <= integ_next_s;
      e_prev_r <= e_s;
    end
  end

endmodule

// File: tb/tb_pid_1.sv
// Directed self-checking bench for pid_1 with default parameters, including
// hand-computed sequences and an integer reference model for the toggle run.
module tb_pid_1;

  logic       clk;
  logic       reset;
  logic [7:0] speed;
  logic [7:0] feed;
  logic [7:0] pwmout;

  int n_cmp;
  int n_bad;

  longint m_integ;
  longint m_eprev;
  longint m_pwm;

  pid_1 dut (
    .clk    (clk),
    .reset  (reset),
    .speed  (speed),
    .feed   (feed),
    .pwmout (pwmout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: default gains 4/1/2, shift 3, limit 4095
  task automatic model_step(input logic [7:0] s, input logic [7:0] f, input logic r);
    longint e, in, d, u, us;
    if (r) begin
      m_integ = 0;
      m_eprev = 0;
      m_pwm   = 0;
    end else begin
      e  = longint'(s) - longint'(f);
      in = m_integ + e;
      if (in > 4095) in = 4095;
      if (in < -4095) in = -4095;
      d  = e - m_eprev;
      u  = 4 * e + 1 * in + 2 * d;
      us = u >>> 3;
      m_pwm   = (us < 0) ? 0 : ((us > 255) ? 255 : us);
      m_integ = in;
      m_eprev = e;
    end
  endtask

  task automatic tick(input logic [7:0] s, input logic [7:0] f, input logic r);
    speed = s;
    feed  = f;
    reset = r;
    @(posedge clk);
    #1;
    model_step(s, f, r);
  endtask

  function automatic longint integ_now();
    longint v;
    v = longint'($signed(dut.integ_r));
    return v;
  endfunction

  initial begin
    longint seq_a [5];
    n_cmp = 0;
    n_bad = 0;
    m_integ = 0;
    m_eprev = 0;
    m_pwm   = 0;
    seq_a[0] = 87; seq_a[1] = 75; seq_a[2] = 87; seq_a[3] = 100; seq_a[4] = 112;
    speed = 8'd0;
    feed  = 8'd0;
    reset = 1'b1;
    @(negedge clk);

    // Reset held for 10 cycles with a large error applied
    for (int i = 0; i < 10; i++) begin
      tick(8'd100, 8'd0, 1'b1);
      check("reset_hold", longint'(pwmout), 0);
    end
    check("reset_integ", integ_now(), 0);

    // Zero error
    for (int i = 0; i < 6; i++) begin
      tick(8'd100, 8'd100, 1'b0);
      check("zero_err", longint'(pwmout), 0);
    end

    // Step response from a fresh reset
    tick(8'd100, 8'd0, 1'b1);
    check("step_reset", longint'(pwmout), 0);
    for (int i = 0; i < 5; i++) begin
      tick(8'd100, 8'd0, 1'b0);
      check("step_seq", longint'(pwmout), seq_a[i]);
    end
    for (int i = 5; i < 30; i++) begin
      tick(8'd100, 8'd0, 1'b0);
      check("step_model", longint'(pwmout), m_pwm);
    end
    check("step_sat", longint'(pwmout), 255);

    // Mid-run reset discards history
    tick(8'd100, 8'd0, 1'b1);
    check("midreset_pwm", longint'(pwmout), 0);
    check("midreset_integ", integ_now(), 0);
    for (int i = 0; i < 5; i++) begin
      tick(8'd100, 8'd0, 1'b0);
      check("restart_seq", longint'(pwmout), seq_a[i]);
    end
    for (int i = 5; i < 45; i++) begin
      tick(8'd100, 8'd0, 1'b0);
    end
    check("pos_sat_pwm", longint'(pwmout), 255);
    check("pos_sat_integ", integ_now(), 4095);

    // Large negative error: output floors at 0, integrator saturates low
    tick(8'd0, 8'd255, 1'b1);
    for (int i = 0; i < 25; i++) begin
      tick(8'd0, 8'd255, 1'b0);
      check("neg_pwm", longint'(pwmout), 0);
    end
    check("neg_sat_integ", integ_now(), -4095);

    // Feedback toggling every 5 cycles against the reference model
    tick(8'd100, 8'd0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      tick(8'd100, ((i / 5) % 2 == 0) ? 8'd0 : 8'd255, 1'b0);
      check("toggle_model", longint'(pwmout), m_pwm);
    end
    check("toggle_integ", integ_now(), m_integ);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
